// File: rtl/ram_arbiter_if.sv
// -----------------------------------------------------------------------------
// ram_arbiter_if
// Bundles the three buses that meet at the RAM arbiter:
//   fetch  : if_req/if_addr in, if_gnt/if_rvalid/if_rdata out
//   data   : d_req/d_we/d_addr/d_wdata in, d_gnt/d_rvalid/d_rdata out
//   RAM    : ram_addr/ram_we/ram_re/ram_wdata out, ram_rdata in
// Modports:
//   slave  : the arbiter itself
//   master : everything around it (fetch unit, LSU and the RAM)
// -----------------------------------------------------------------------------
interface ram_arbiter_if #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int WDATA_W = 8
);
    // fetch requester
    logic               if_req;
    logic [ADDR_W-1:0]  if_addr;
    logic               if_gnt;
    logic               if_rvalid;
    logic [DATA_W-1:0]  if_rdata;

    // load/store requester
    logic               d_req;
    logic               d_we;
    logic [ADDR_W-1:0]  d_addr;
    logic [WDATA_W-1:0] d_wdata;
    logic               d_gnt;
    logic               d_rvalid;
    logic [DATA_W-1:0]  d_rdata;

    // RAM port
    logic [ADDR_W-1:0]  ram_addr;
    logic               ram_we;
    logic               ram_re;
    logic [WDATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0]  ram_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output ram_addr, ram_we, ram_re, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  ram_addr, ram_we, ram_re, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
// Shares the single-ported 32x32 unified RAM between instruction fetch
// (read-only) and the load/store unit (read or byte write). One access per
// cycle, round-robin on conflict, grant is combinational (zero latency).
// The RAM returns read data one cycle after ram_re; the arbiter remembers who
// issued the read and steers the data back to that requester only.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   bus          ram_arbiter_if.slave (fetch, data and RAM buses)
//   stat_clr     synchronous clear of the conflict counter
//   conflict_cnt saturating count of cycles with both requests asserted
// -----------------------------------------------------------------------------
module ram_arbiter #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int WDATA_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    ram_arbiter_if.slave    bus,
    input  logic            stat_clr,
    output logic [7:0]      conflict_cnt
);

    localparam logic WIN_FETCH = 1'b0;
    localparam logic WIN_DATA  = 1'b1;

    // last_win resets to "data" so that fetch takes the first conflict
    logic       last_win_q, last_win_d;
    logic       rd_pend_q,  rd_pend_d;
    logic       rd_owner_q, rd_owner_d;
    logic [7:0] cnt_q,      cnt_d;

    logic       if_win;
    logic       d_win;
    logic       conflict;

    // ------------------------------------------------------------------
    // Grant decision
    // ------------------------------------------------------------------
    always_comb begin
        conflict = bus.if_req & bus.d_req;
        // On conflict the requester that did not win last time goes first.
        if_win   = bus.if_req & (~bus.d_req | (last_win_q == WIN_DATA));
        d_win    = bus.d_req  & (~bus.if_req | (last_win_q == WIN_FETCH));
    end

    assign bus.if_gnt = if_win;
    assign bus.d_gnt  = d_win;

    // ------------------------------------------------------------------
    // RAM port drive; everything is zero when nobody is granted
    // ------------------------------------------------------------------
    always_comb begin
        bus.ram_addr  = '0;
        bus.ram_we    = 1'b0;
        bus.ram_re    = 1'b0;
        bus.ram_wdata = '0;
        if (if_win) begin
            bus.ram_addr = bus.if_addr;
            bus.ram_re   = 1'b1;
        end else if (d_win) begin
            bus.ram_addr = bus.d_addr;
            if (bus.d_we) begin
                bus.ram_we    = 1'b1;
                bus.ram_wdata = bus.d_wdata;
            end else begin
                bus.ram_re = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        last_win_d = last_win_q;
        rd_pend_d  = 1'b0;
        rd_owner_d = rd_owner_q;
        cnt_d      = cnt_q;

        if (if_win) begin
            last_win_d = WIN_FETCH;
        end else if (d_win) begin
            last_win_d = WIN_DATA;
        end

        // Writes are fire-and-forget; only reads leave a pending return.
        if (if_win) begin
            rd_pend_d  = 1'b1;
            rd_owner_d = WIN_FETCH;
        end else if (d_win && !bus.d_we) begin
            rd_pend_d  = 1'b1;
            rd_owner_d = WIN_DATA;
        end

        // Clear wins over a same-cycle increment.
        if (stat_clr) begin
            cnt_d = '0;
        end else if (conflict && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_win_q <= WIN_DATA;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= WIN_FETCH;
            cnt_q      <= '0;
        end else begin
            last_win_q <= last_win_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
            cnt_q      <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Read-data return; rdata is forced to zero unless it belongs to you
    // ------------------------------------------------------------------
    always_comb begin
        bus.if_rvalid = rd_pend_q & (rd_owner_q == WIN_FETCH);
        bus.d_rvalid  = rd_pend_q & (rd_owner_q == WIN_DATA);
        bus.if_rdata  = bus.if_rvalid ? bus.ram_rdata : '0;
        bus.d_rdata   = bus.d_rvalid  ? bus.ram_rdata : '0;
    end

    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        stat_clr;
    logic [7:0]  conflict_cnt;

    int n_checks;
    int n_errors;

    ram_arbiter_if #(.ADDR_W(5), .DATA_W(32), .WDATA_W(8)) bus ();

    ram_arbiter #(.ADDR_W(5), .DATA_W(32), .WDATA_W(8)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .stat_clr     (stat_clr),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered read, byte write zero-extended to 32 bits
    logic [31:0] mem [0:31];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= {24'b0, bus.ram_wdata};
        if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic ir, input logic [4:0] ia,
                           input logic dr, input logic dw,
                           input logic [4:0] da, input logic [7:0] dd);
        bus.if_req  = ir;
        bus.if_addr = ia;
        bus.d_req   = dr;
        bus.d_we    = dw;
        bus.d_addr  = da;
        bus.d_wdata = dd;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_if_rvalid", {31'b0, bus.if_rvalid}, 32'd0);
        check("rst_d_rvalid",  {31'b0, bus.d_rvalid},  32'd0);
        check("rst_if_rdata",  bus.if_rdata, 32'd0);
        check("rst_d_rdata",   bus.d_rdata,  32'd0);
        check("rst_cnt",       {24'b0, conflict_cnt}, 32'd0);
        next_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        mem[3] = 32'h0000_00A5;
        bus.ram_rdata = 32'd0;
        stat_clr = 1'b0;
        set_req(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 8'd0);
        rst_n = 1'b0;
        #12;
        do_reset();

        // ---------------- idle ----------------
        @(negedge clk);
        check("idle_if_gnt", {31'b0, bus.if_gnt}, 32'd0);
        check("idle_d_gnt",  {31'b0, bus.d_gnt},  32'd0);
        check("idle_ram_we", {31'b0, bus.ram_we}, 32'd0);
        check("idle_ram_re", {31'b0, bus.ram_re}, 32'd0);
        check("idle_ram_addr", {27'b0, bus.ram_addr}, 32'd0);
        check("idle_rvalid", {30'b0, bus.if_rvalid, bus.d_rvalid}, 32'd0);
        next_cycle();

        // ---------------- fetch-only read ----------------
        set_req(1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 8'd0);
        @(negedge clk);
        check("f_if_gnt",   {31'b0, bus.if_gnt}, 32'd1);
        check("f_d_gnt",    {31'b0, bus.d_gnt},  32'd0);
        check("f_ram_re",   {31'b0, bus.ram_re}, 32'd1);
        check("f_ram_addr", {27'b0, bus.ram_addr}, 32'd3);
        check("f_d_rvalid0", {31'b0, bus.d_rvalid}, 32'd0);
        next_cycle();
        set_req(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 8'd0);
        @(negedge clk);
        check("f_if_rvalid", {31'b0, bus.if_rvalid}, 32'd1);
        check("f_if_rdata",  bus.if_rdata, 32'h0000_00A5);
        check("f_d_rvalid1", {31'b0, bus.d_rvalid}, 32'd0);
        check("f_d_rdata",   bus.d_rdata, 32'd0);
        next_cycle();

        // ---------------- data write then read ----------------
        set_req(1'b0, 5'd0, 1'b1, 1'b1, 5'd7, 8'h3C);
        @(negedge clk);
        check("w_d_gnt",     {31'b0, bus.d_gnt},  32'd1);
        check("w_ram_we",    {31'b0, bus.ram_we}, 32'd1);
        check("w_ram_re",    {31'b0, bus.ram_re}, 32'd0);
        check("w_ram_addr",  {27'b0, bus.ram_addr}, 32'd7);
        check("w_ram_wdata", {24'b0, bus.ram_wdata}, 32'h3C);
        next_cycle();
        set_req(1'b0, 5'd0, 1'b1, 1'b0, 5'd7, 8'h00);
        @(negedge clk);
        check("r_d_gnt",     {31'b0, bus.d_gnt},  32'd1);
        check("r_ram_re",    {31'b0, bus.ram_re}, 32'd1);
        check("r_no_rvalid", {30'b0, bus.if_rvalid, bus.d_rvalid}, 32'd0);
        next_cycle();
        set_req(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 8'd0);
        @(negedge clk);
        check("r_d_rvalid",  {31'b0, bus.d_rvalid}, 32'd1);
        check("r_d_rdata",   bus.d_rdata, 32'h0000_003C);
        check("r_if_rvalid", {31'b0, bus.if_rvalid}, 32'd0);
        next_cycle();

        // ---------------- continuous conflict after reset ----------------
        do_reset();
        set_req(1'b1, 5'd3, 1'b1, 1'b0, 5'd7, 8'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("c%0d_if_gnt", k), {31'b0, bus.if_gnt}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("c%0d_d_gnt", k),  {31'b0, bus.d_gnt},  (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k > 0) begin
                check($sformatf("c%0d_if_rvalid", k), {31'b0, bus.if_rvalid}, (k % 2 == 1) ? 32'd1 : 32'd0);
                check($sformatf("c%0d_d_rvalid", k),  {31'b0, bus.d_rvalid},  (k % 2 == 0) ? 32'd1 : 32'd0);
                check($sformatf("c%0d_if_rdata", k), bus.if_rdata, (k % 2 == 1) ? 32'h0000_00A5 : 32'd0);
                check($sformatf("c%0d_d_rdata", k),  bus.d_rdata,  (k % 2 == 0) ? 32'h0000_003C : 32'd0);
            end
            next_cycle();
        end
        set_req(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 8'd0);
        @(negedge clk);
        check("c_tail_d_rvalid",  {31'b0, bus.d_rvalid},  32'd1);
        check("c_tail_if_rvalid", {31'b0, bus.if_rvalid}, 32'd0);
        check("c_cnt4", {24'b0, conflict_cnt}, 32'd4);
        next_cycle();

        // ---------------- counter saturation and clear ----------------
        set_req(1'b1, 5'd3, 1'b1, 1'b0, 5'd7, 8'd0);
        for (int k = 0; k < 300; k++) next_cycle();
        @(negedge clk);
        check("sat_cnt", {24'b0, conflict_cnt}, 32'd255);
        next_cycle();
        stat_clr = 1'b1;
        next_cycle();
        stat_clr = 1'b0;
        @(negedge clk);
        check("clr_cnt0", {24'b0, conflict_cnt}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("clr_cnt1", {24'b0, conflict_cnt}, 32'd1);
        next_cycle();
        set_req(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 8'd0);
        next_cycle();

        // ---------------- reset mid-read ----------------
        set_req(1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 8'd0);
        @(negedge clk);
        check("mr_if_gnt", {31'b0, bus.if_gnt}, 32'd1);
        rst_n = 1'b0;
        next_cycle();
        set_req(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 8'd0);
        @(negedge clk);
        check("mr_c1_if_rvalid", {31'b0, bus.if_rvalid}, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("mr_c2_if_rvalid", {31'b0, bus.if_rvalid}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("mr_c3_if_rvalid", {31'b0, bus.if_rvalid}, 32'd0);
        next_cycle();
        set_req(1'b1, 5'd3, 1'b1, 1'b0, 5'd7, 8'd0);
        @(negedge clk);
        check("mr_conf_if_gnt", {31'b0, bus.if_gnt}, 32'd1);
        check("mr_conf_d_gnt",  {31'b0, bus.d_gnt},  32'd0);
        next_cycle();
        set_req(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 8'd0);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
